// File: rtl/fifo_pop_serializer_pkg.sv
// Shared types for the FIFO pop-side serializer.
package fifo_pop_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_pop_serializer.sv
// Pops wide words from a synchronous FIFO and streams each one out as RATIO
// narrow valid/ready beats, back-to-back with no bubble between words.
//
//   state | meaning
//   IDLE  | no word held; pop as soon as the FIFO has data
//   SEND  | word in hold_q, presenting slice beat_q on the stream
module fifo_pop_serializer
  import fifo_pop_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter int RATIO      = DATA_WIDTH / OUT_WIDTH,
  parameter int CNT_W      = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_pop_o,
  output logic                  out_valid_o,
  output logic [OUT_WIDTH-1:0]  out_data_o,
  output logic                  out_last_o,
  input  logic                  out_ready_i,
  output logic                  busy_o
);

  if (OUT_WIDTH <= 0 || (DATA_WIDTH % OUT_WIDTH) != 0) begin : g_bad_cfg
    $error("fifo_pop_serializer: DATA_WIDTH must be a positive multiple of OUT_WIDTH");
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]      beat_q, beat_d;
  logic [CNT_W-1:0]      slice_idx;
  logic [OUT_WIDTH-1:0]  slice;
  logic                  last_beat;
  logic                  pop;

  assign slice_idx = MSB_FIRST ? (LAST_IDX - beat_q) : beat_q;
  assign slice     = hold_q[slice_idx*OUT_WIDTH +: OUT_WIDTH];
  assign last_beat = (beat_q == LAST_IDX);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      hold_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    beat_d      = beat_q;
    pop         = 1'b0;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_i && !flush_i) begin
          pop     = 1'b1;
          hold_d  = fifo_data_i;
          beat_d  = '0;
          state_d = SEND;
        end else if (flush_i) begin
          beat_d = '0;
        end
      end
      SEND: begin
        out_valid_o = 1'b1;
        out_data_o  = slice;
        out_last_o  = last_beat;
        // Flush wins over a same-cycle handshake: that beat is not transferred.
        if (flush_i) begin
          state_d = IDLE;
          beat_d  = '0;
        end else if (out_ready_i) begin
          if (!last_beat) begin
            beat_d = beat_q + 1'b1;
          end else if (!fifo_empty_i) begin
            pop    = 1'b1;
            hold_d = fifo_data_i;
            beat_d = '0;
          end else begin
            state_d = IDLE;
            beat_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_pop_o = pop & ~rst_i;
  assign busy_o     = (state_q == SEND);

`ifndef SYNTHESIS
  a_pop_nonempty: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_pop_o |-> !fifo_empty_i);

  a_beat_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !flush_i) |=>
      ($stable(out_data_o) && $stable(out_last_o)));
`endif

endmodule

// File: tb/tb_fifo_pop_serializer.sv
// Self-checking bench: directed vector table, queue-based reference model
// under random stimulus, and an MSB-first RATIO=2 instance.
module tb_fifo_pop_serializer;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, fifo_empty_i, out_ready_i;
  logic [31:0] fifo_data_i;
  logic        fifo_pop_o, out_valid_o, out_last_o, busy_o;
  logic [7:0]  out_data_o;

  logic        b_empty, b_ready, b_flush, b_pop, b_valid, b_last, b_busy;
  logic [15:0] b_data_in;
  logic [7:0]  b_data_out;

  always #5 clk_i = ~clk_i;

  fifo_pop_serializer #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_last_o(out_last_o),
    .out_ready_i(out_ready_i), .busy_o(busy_o));

  fifo_pop_serializer #(.DATA_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(b_flush),
    .fifo_empty_i(b_empty), .fifo_data_i(b_data_in), .fifo_pop_o(b_pop),
    .out_valid_o(b_valid), .out_data_o(b_data_out), .out_last_o(b_last),
    .out_ready_i(b_ready), .busy_o(b_busy));

  typedef struct {
    bit          ready;
    bit          flush;
    bit          pop;
    bit          valid;
    logic [7:0]  data;
    bit          last;
    int          npush;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    bit         l;
  } beat_t;

  vec_t        vecs[$];
  beat_t       beats[$];
  logic [31:0] fifo_q[$];
  int          checks = 0;
  int          failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic vec_t mk(bit r, bit f, bit p, bit v, logic [7:0] d, bit l,
                              int n = 0, logic [31:0] w0 = 0, logic [31:0] w1 = 0);
    vec_t x;
    x.ready = r; x.flush = f; x.pop = p; x.valid = v; x.data = d; x.last = l;
    x.npush = n; x.w0 = w0; x.w1 = w1;
    return x;
  endfunction

  task automatic fifo_refresh();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = fifo_empty_i ? 32'h0 : fifo_q[0];
  endtask

  // One clock cycle: inputs already set; sample, compare, advance the model.
  task automatic tick(input bit use_vec, input vec_t v);
    bit          exp_pop, s_pop, s_hs, s_flush;
    logic [31:0] head;
    #1;
    if (rst_i) beats.delete();
    exp_pop = !rst_i && !fifo_empty_i && !flush_i &&
              (beats.size() == 0 || (beats.size() == 1 && out_ready_i));
    chk("model_pop", fifo_pop_o, exp_pop);
    chk("model_valid", out_valid_o, beats.size() != 0);
    chk("model_busy", busy_o, beats.size() != 0);
    if (beats.size() != 0) begin
      chk("model_data", out_data_o, beats[0].d);
      chk("model_last", out_last_o, beats[0].l);
    end
    if (use_vec) begin
      chk("vec_pop", fifo_pop_o, v.pop);
      chk("vec_valid", out_valid_o, v.valid);
      if (v.valid) begin
        chk("vec_data", out_data_o, v.data);
        chk("vec_last", out_last_o, v.last);
      end
    end
    s_pop   = fifo_pop_o;
    s_hs    = (beats.size() != 0) && out_ready_i && !flush_i;
    s_flush = flush_i;
    head    = fifo_data_i;
    @(posedge clk_i);
    #1;
    if (s_flush) beats.delete();
    else if (s_hs) void'(beats.pop_front());
    if (s_pop && fifo_q.size() != 0) begin
      for (int i = 0; i < 4; i++) begin
        beat_t b;
        b.d = head[8*i +: 8];
        b.l = (i == 3);
        beats.push_back(b);
      end
      void'(fifo_q.pop_front());
    end
    fifo_refresh();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dummy;
    dummy = mk(0, 0, 0, 0, 8'h00, 0);

    // single word
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 0, 1, 32'hA1B2C3D4));
    vecs.push_back(mk(1, 0, 0, 1, 8'hD4, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'hC3, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'hB2, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'hA1, 1));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0));
    // back-to-back: second pop on the accepted 0x11 beat
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 0, 2, 32'h11223344, 32'h55667788));
    vecs.push_back(mk(1, 0, 0, 1, 8'h44, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h33, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h22, 0));
    vecs.push_back(mk(1, 0, 1, 1, 8'h11, 1));
    vecs.push_back(mk(1, 0, 0, 1, 8'h88, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h77, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h66, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h55, 1));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0));
    // backpressure 1,0,0,1,0,1,1
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 0, 1, 32'h0000BEEF));
    vecs.push_back(mk(1, 0, 0, 1, 8'hEF, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hBE, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'hBE, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'hBE, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 1));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0));
    // flush after two beats, next word restarts at its first slice
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 0, 2, 32'hCAFEF00D, 32'h12345678));
    vecs.push_back(mk(1, 0, 0, 1, 8'h0D, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'hF0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 8'hFE, 0));
    vecs.push_back(mk(1, 0, 1, 0, 8'h00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h78, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h56, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h34, 0));
    vecs.push_back(mk(1, 0, 0, 1, 8'h12, 1));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0));

    rst_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    b_empty = 1'b1; b_data_in = 16'h0; b_ready = 1'b1; b_flush = 1'b0;
    fifo_refresh();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_pop", fifo_pop_o, 0);
    chk("rst_valid", out_valid_o, 0);
    rst_i = 1'b0;
    repeat (10) begin
      #1;
      chk("idle_pop", fifo_pop_o, 0);
      chk("idle_valid", out_valid_o, 0);
      chk("idle_data", out_data_o, 0);
      chk("idle_last", out_last_o, 0);
      chk("idle_busy", busy_o, 0);
      @(posedge clk_i);
      #1;
    end

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].npush > 0) fifo_q.push_back(vecs[i].w0);
      if (vecs[i].npush > 1) fifo_q.push_back(vecs[i].w1);
      fifo_refresh();
      out_ready_i = vecs[i].ready;
      flush_i     = vecs[i].flush;
      tick(1'b1, vecs[i]);
    end

    for (int c = 0; c < 3000; c++) begin
      out_ready_i = ($urandom_range(0, 9) < 7);
      flush_i     = ($urandom_range(0, 59) == 0);
      rst_i       = ($urandom_range(0, 249) == 0);
      if (fifo_q.size() < 3 && $urandom_range(0, 2) != 0) fifo_q.push_back($urandom);
      fifo_refresh();
      tick(1'b0, dummy);
    end
    rst_i = 1'b0; flush_i = 1'b0;
    fifo_q.delete();
    fifo_refresh();
    repeat (6) tick(1'b0, dummy);

    // MSB-first, RATIO=2
    b_empty = 1'b0; b_data_in = 16'hABCD;
    #1;
    chk("msb_pop", b_pop, 1);
    chk("msb_valid0", b_valid, 0);
    @(posedge clk_i);
    #1;
    b_empty = 1'b1;
    #1;
    chk("msb_pop_none", b_pop, 0);
    chk("msb_valid1", b_valid, 1);
    chk("msb_beat0", b_data_out, 8'hAB);
    chk("msb_last0", b_last, 0);
    @(posedge clk_i);
    #2;
    chk("msb_beat1", b_data_out, 8'hCD);
    chk("msb_last1", b_last, 1);
    @(posedge clk_i);
    #2;
    chk("msb_done", b_valid, 0);
    chk("msb_busy", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
